// File: rtl/cache_bus2_initiator.sv
// Cache-side bus2 initiator: issues one line read or write at a time and streams the line
// over D2 in 16-bit little-endian beats. It then waits for C2_RESPONSE, with an optional timeout.
module cache_bus2_initiator #(
  parameter int unsigned ADDR2_BUS_SIZE  = 15,
  parameter int unsigned DATA_BUS_SIZE   = 16,
  parameter int unsigned CACHE_LINE_SIZE = 16,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         req_valid,
  input  logic                         req_write,
  input  logic [ADDR2_BUS_SIZE-1:0]    req_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0] req_line,
  output logic                         req_ready,
  output logic                         resp_valid,
  output logic [CACHE_LINE_SIZE*8-1:0] resp_line,
  output logic                         err,
  output logic [ADDR2_BUS_SIZE-1:0]    A2_OUT,
  output logic                         A2_OE,
  output logic [DATA_BUS_SIZE-1:0]     D2_OUT,
  output logic                         D2_OE,
  input  logic [DATA_BUS_SIZE-1:0]     D2_IN,
  output logic [1:0]                   C2_OUT,
  output logic                         C2_OE,
  input  logic [1:0]                   C2_IN
);

  localparam int unsigned LINE_W  = CACHE_LINE_SIZE * 8;
  localparam int unsigned BEATS   = CACHE_LINE_SIZE / 2;
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [1:0] C2_NOP        = 2'd0;
  localparam logic [1:0] C2_RESPONSE   = 2'd1;
  localparam logic [1:0] C2_READ_LINE  = 2'd2;
  localparam logic [1:0] C2_WRITE_LINE = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DATA, S_RD_CMD, S_TURN, S_WAIT_RESP, S_RD_DATA
  } state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR2_BUS_SIZE-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [LINE_W-1:0]       resp_line_q, resp_line_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    err_q, err_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      line_q       <= '0;
      beat_q       <= '0;
      to_cnt_q     <= '0;
      resp_line_q  <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      beat_q       <= beat_d;
      to_cnt_q     <= to_cnt_d;
      resp_line_q  <= resp_line_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    line_d       = line_q;
    beat_d       = beat_q;
    to_cnt_d     = to_cnt_q;
    resp_line_d  = resp_line_q;
    resp_valid_d = 1'b0;
    err_d        = 1'b0;

    req_ready = 1'b0;
    A2_OE     = 1'b0;
    D2_OE     = 1'b0;
    C2_OE     = 1'b0;
    C2_OUT    = C2_NOP;
    D2_OUT    = line_q[32'(beat_q)*DATA_BUS_SIZE +: DATA_BUS_SIZE];

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        C2_OE     = 1'b1;
        if (req_valid) begin
          write_d  = req_write;
          addr_d   = req_addr;
          line_d   = req_line;
          beat_d   = '0;
          to_cnt_d = '0;
          state_d  = req_write ? S_WR_DATA : S_RD_CMD;
        end
      end
      S_WR_DATA: begin
        D2_OE = 1'b1;
        C2_OE = 1'b1;
        if (beat_q == '0) begin
          C2_OUT = C2_WRITE_LINE;
          A2_OE  = 1'b1;
        end
        if (beat_q == LAST_BEAT) state_d = S_TURN;
        else                     beat_d  = beat_q + BEAT_W'(1);
      end
      S_RD_CMD: begin
        C2_OE   = 1'b1;
        C2_OUT  = C2_READ_LINE;
        A2_OE   = 1'b1;
        state_d = S_TURN;
      end
      S_TURN: begin
        C2_OE   = 1'b1;
        state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (C2_IN == C2_RESPONSE) begin
          if (write_q) begin
            resp_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            line_d[DATA_BUS_SIZE-1:0] = D2_IN;
            if (BEATS == 1) begin
              resp_valid_d = 1'b1;
              resp_line_d  = line_d;
              state_d      = S_IDLE;
            end else begin
              beat_d  = BEAT_W'(1);
              state_d = S_RD_DATA;
            end
          end
        end else if (TIMEOUT != 0 && to_cnt_q == TO_W'(TO_LAST)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_RD_DATA: begin
        // responder owns the bus here; C2_IN is deliberately not looked at
        line_d[32'(beat_q)*DATA_BUS_SIZE +: DATA_BUS_SIZE] = D2_IN;
        if (beat_q == LAST_BEAT) begin
          resp_valid_d = 1'b1;
          resp_line_d  = line_d;
          state_d      = S_IDLE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign A2_OUT     = addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_line  = resp_line_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cache_bus2_initiator.sv
// Directed bench for cache_bus2_initiator: reset, write, read, timeout (second instance with
// TIMEOUT=4), busy/back-to-back acceptance and reset in the middle of a read.
module tb_cache_bus2_initiator;

  localparam logic [1:0] C2_NOP = 2'd0, C2_RSP = 2'd1, C2_RD = 2'd2, C2_WR = 2'd3;

  logic         clk = 1'b0;
  logic         RESET = 1'b1;
  logic         req_valid = 1'b0, req_write = 1'b0;
  logic [14:0]  req_addr = '0;
  logic [127:0] req_line = '0;
  logic [15:0]  d2_in = '0;
  logic [1:0]   c2_in = C2_NOP;

  logic         req_ready, resp_valid, err, a2_oe, d2_oe, c2_oe;
  logic [127:0] resp_line;
  logic [14:0]  a2_out;
  logic [15:0]  d2_out;
  logic [1:0]   c2_out;

  logic         t_req_valid = 1'b0;
  logic         t_req_ready, t_resp_valid, t_err, t_a2_oe, t_d2_oe, t_c2_oe;
  logic [127:0] t_resp_line;
  logic [14:0]  t_a2_out;
  logic [15:0]  t_d2_out;
  logic [1:0]   t_c2_out;

  int n_chk = 0;
  int n_err = 0;
  int seen;

  always #5 clk = ~clk;

  cache_bus2_initiator dut (
    .CLK(clk), .RESET(RESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_line(req_line),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_line(resp_line), .err(err),
    .A2_OUT(a2_out), .A2_OE(a2_oe), .D2_OUT(d2_out), .D2_OE(d2_oe), .D2_IN(d2_in),
    .C2_OUT(c2_out), .C2_OE(c2_oe), .C2_IN(c2_in)
  );

  cache_bus2_initiator #(.TIMEOUT(4)) dut_to (
    .CLK(clk), .RESET(RESET),
    .req_valid(t_req_valid), .req_write(req_write), .req_addr(req_addr), .req_line(req_line),
    .req_ready(t_req_ready), .resp_valid(t_resp_valid), .resp_line(t_resp_line), .err(t_err),
    .A2_OUT(t_a2_out), .A2_OE(t_a2_oe), .D2_OUT(t_d2_out), .D2_OE(t_d2_oe), .D2_IN(d2_in),
    .C2_OUT(t_c2_out), .C2_OE(t_c2_oe), .C2_IN(C2_NOP)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".c2_oe"}, c2_oe, 1'b1);
    chk({tag, ".c2_out"}, c2_out, C2_NOP);
    chk({tag, ".a2_oe"}, a2_oe, 1'b0);
    chk({tag, ".d2_oe"}, d2_oe, 1'b0);
    chk({tag, ".req_ready"}, req_ready, 1'b1);
  endtask

  initial begin
    // ---- reset ----
    RESET = 1'b1;
    tick();
    tick();
    chk_idle("rst");
    chk("rst.resp_valid", resp_valid, 1'b0);
    chk("rst.err", err, 1'b0);
    chk("rst.resp_line", resp_line, 128'h0);
    RESET = 1'b0;
    tick();

    // ---- write 0x0005, bytes 0x00..0x0F; a stray response during TURN must be ignored ----
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0005;
    req_line  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    tick();
    req_valid = 1'b0;
    chk("wr.cmd", c2_out, C2_WR);
    chk("wr.a2_oe0", a2_oe, 1'b1);
    chk("wr.a2_out", a2_out, 15'h0005);
    for (int k = 0; k < 8; k++) begin
      chk("wr.d2_oe", d2_oe, 1'b1);
      chk("wr.d2_out", d2_out, {8'(2*k+1), 8'(2*k)});
      chk("wr.busy", req_ready, 1'b0);
      if (k > 0) begin
        chk("wr.nop", c2_out, C2_NOP);
        chk("wr.a2_off", a2_oe, 1'b0);
      end
      tick();
    end
    chk("wr.turn_c2oe", c2_oe, 1'b1);
    chk("wr.turn_c2", c2_out, C2_NOP);
    chk("wr.turn_d2oe", d2_oe, 1'b0);
    c2_in = C2_RSP;
    tick();
    c2_in = C2_NOP;
    for (int i = 0; i < 4; i++) begin
      chk("wr.rel_c2oe", c2_oe, 1'b0);
      chk("wr.rel_a2oe", a2_oe, 1'b0);
      chk("wr.rel_d2oe", d2_oe, 1'b0);
      chk("wr.no_resp", resp_valid, 1'b0);
      tick();
    end
    c2_in = C2_RSP;
    tick();
    c2_in = C2_NOP;
    chk("wr.resp", resp_valid, 1'b1);
    chk_idle("wr.done");
    tick();
    chk("wr.resp_pulse", resp_valid, 1'b0);

    // ---- read 0x1234, response on first WAIT_RESP edge ----
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h1234; req_line = '1;
    tick();
    req_valid = 1'b0;
    chk("rd.cmd", c2_out, C2_RD);
    chk("rd.cmd_oe", c2_oe, 1'b1);
    chk("rd.a2_oe", a2_oe, 1'b1);
    chk("rd.a2_out", a2_out, 15'h1234);
    chk("rd.d2_oe", d2_oe, 1'b0);
    tick();
    chk("rd.turn", c2_out, C2_NOP);
    chk("rd.turn_a2", a2_oe, 1'b0);
    tick();
    chk("rd.released", c2_oe, 1'b0);
    c2_in = C2_RSP; d2_in = 16'hBBAA;
    tick();
    c2_in = C2_NOP;
    for (int k = 1; k < 8; k++) begin
      d2_in = {8'(2*k+1), 8'(2*k)};
      chk("rd.no_resp", resp_valid, 1'b0);
      tick();
    end
    chk("rd.resp", resp_valid, 1'b1);
    chk("rd.line", resp_line, 128'h0F0E0D0C_0B0A0908_07060504_0302BBAA);
    tick();
    chk("rd.resp_pulse", resp_valid, 1'b0);
    chk("rd.line_held", resp_line, 128'h0F0E0D0C_0B0A0908_07060504_0302BBAA);

    // ---- timeout on the TIMEOUT=4 instance ----
    req_write = 1'b0; req_addr = 15'h0042; t_req_valid = 1'b1;
    tick();
    t_req_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      chk("to.no_err", t_err, 1'b0);
      chk("to.busy", t_req_ready, 1'b0);
      tick();
    end
    chk("to.err", t_err, 1'b1);
    chk("to.idle", t_req_ready, 1'b1);
    chk("to.c2oe", t_c2_oe, 1'b1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen += int'(t_err) + int'(t_resp_valid);
    end
    chk("to.quiet", seen, 0);

    // ---- busy requests ignored, then back-to-back read ----
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0011; req_line = 128'h5;
    tick();
    req_write = 1'b0; req_addr = 15'h2222;
    for (int k = 0; k < 8; k++) begin
      req_valid = k[0];
      chk("b2b.busy", req_ready, 1'b0);
      chk("b2b.c2", c2_out, (k == 0) ? C2_WR : C2_NOP);
      tick();
    end
    req_valid = 1'b1;
    chk("b2b.turn", c2_out, C2_NOP);
    tick();
    c2_in = C2_RSP;
    tick();
    c2_in = C2_NOP;
    chk("b2b.resp", resp_valid, 1'b1);
    chk("b2b.ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("b2b.cmd", c2_out, C2_RD);
    chk("b2b.addr", a2_out, 15'h2222);

    // ---- reset at read beat 3 ----
    tick();
    tick();
    c2_in = C2_RSP; d2_in = 16'h1111;
    tick();
    c2_in = C2_NOP;
    for (int k = 1; k < 3; k++) begin
      d2_in = 16'h2222 + 16'(k);
      tick();
    end
    d2_in = 16'h3333; RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_idle("mid");
    chk("mid.resp_valid", resp_valid, 1'b0);
    chk("mid.err", err, 1'b0);
    chk("mid.line", resp_line, 128'h0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      d2_in = 16'h4444;
      tick();
      seen += int'(resp_valid) + int'(err);
    end
    chk("mid.quiet", seen, 0);

    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0003;
    req_line  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    tick();
    req_valid = 1'b0;
    chk("post.cmd", c2_out, C2_WR);
    chk("post.d2", d2_out, 16'hEEFF);
    for (int k = 0; k < 9; k++) tick();
    c2_in = C2_RSP;
    tick();
    c2_in = C2_NOP;
    chk("post.resp", resp_valid, 1'b1);
    chk("post.err", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
